bht_update_queue: RTL and testbench

Commit-side writer for the local branch history table. Buffers resolved, committed conditional-branch outcomes arriving from the retire stage (up to two per cycle, in program order) and drains them one per cycle into the history table's single write port as an index/direction/shift-enable triple. Also flags when a fetch-side history read targets an entry that still has updates pending, so fetch can mark that prediction as using stale history.

---
 rtl/bht_update_queue_if.sv | 32 +++
 rtl/bht_update_queue.sv | 77 +++++++
 tb/tb_bht_update_queue.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bht_update_queue_if.sv
// bht_update_queue_if: retire-side pushes, history-table write port and fetch-side pending lookup
interface bht_update_queue_if #(parameter int DEPTH = 8, parameter int IDXW = 10);
  localparam int CW = $clog2(DEPTH) + 1;
  logic            cm0_valid_i;
  logic [IDXW-1:0] cm0_index_i;
  logic            cm0_brdir_i;
  logic            cm1_valid_i;
  logic [IDXW-1:0] cm1_index_i;
  logic            cm1_brdir_i;
  logic            cm_ready_o;
  logic            bht_hold_i;
  logic [IDXW-1:0] bht_wt_index_o;
  logic            bht_cm_brdir_o;
  logic            bht_cm_brdir_se_o;
  logic [IDXW-1:0] rd_index_i;
  logic            rd_pending_o;
  logic [CW-1:0]   count_o;
  logic            empty_o;
  logic            ovf_err_o;
  modport slave (
    input  cm0_valid_i, cm0_index_i, cm0_brdir_i, cm1_valid_i, cm1_index_i, cm1_brdir_i,
    input  bht_hold_i, rd_index_i,
    output cm_ready_o, bht_wt_index_o, bht_cm_brdir_o, bht_cm_brdir_se_o,
    output rd_pending_o, count_o, empty_o, ovf_err_o
  );
  modport master (
    output cm0_valid_i, cm0_index_i, cm0_brdir_i, cm1_valid_i, cm1_index_i, cm1_brdir_i,
    output bht_hold_i, rd_index_i,
    input  cm_ready_o, bht_wt_index_o, bht_cm_brdir_o, bht_cm_brdir_se_o,
    input  rd_pending_o, count_o, empty_o, ovf_err_o
  );
endinterface

// File: rtl/bht_update_queue.sv
// bht_update_queue: buffers committed branch outcomes and drains one per cycle into the history table
module bht_update_queue #(
  parameter int DEPTH = 8,
  parameter int IDXW  = 10
) (
  input logic clock,
  input logic reset_n,
  bht_update_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  logic [IDXW-1:0] idx_mem [DEPTH];
  logic            dir_mem [DEPTH];
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d, cnt;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            dir_q, dir_d, se_q, se_d, ovf_q, ovf_d;
  logic            ready, empty, p0, p1, pop, hit;
  logic [AW-1:0]   rel, w1;
  always_comb begin
    cnt   = wr_q - rd_q;
    empty = wr_q == rd_q;
    ready = ((AW+1)'(DEPTH) - cnt) >= (AW+1)'(2);
    p0    = q.cm0_valid_i && ready;
    p1    = q.cm1_valid_i && ready;
    pop   = !empty && !q.bht_hold_i;
    w1    = wr_q[AW-1:0] + AW'(p0);
    wr_d  = wr_q + (AW+1)'(p0) + (AW+1)'(p1);
    rd_d  = rd_q + (AW+1)'(pop);
    ovf_d = ovf_q | ((q.cm0_valid_i | q.cm1_valid_i) & ~ready);
    se_d  = pop;
    idx_d = pop ? idx_mem[rd_q[AW-1:0]] : idx_q;
    dir_d = pop ? dir_mem[rd_q[AW-1:0]] : dir_q;
  end
  // the entry being written to the table this cycle still counts as pending
  always_comb begin
    rel = '0;
    hit = se_q && (idx_q == q.rd_index_i);
    for (int i = 0; i < DEPTH; i++) begin
      rel = AW'(i) - rd_q[AW-1:0];
      hit = hit | (({1'b0, rel} < cnt) && (idx_mem[i] == q.rd_index_i));
    end
  end
  always_ff @(posedge clock) begin
    if (p0) begin
      idx_mem[wr_q[AW-1:0]] <= q.cm0_index_i;
      dir_mem[wr_q[AW-1:0]] <= q.cm0_brdir_i;
    end
    if (p1) begin
      idx_mem[w1] <= q.cm1_index_i;
      dir_mem[w1] <= q.cm1_brdir_i;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      idx_q <= '0;
      dir_q <= 1'b0;
      se_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      idx_q <= idx_d;
      dir_q <= dir_d;
      se_q  <= se_d;
      ovf_q <= ovf_d;
    end
  end
  assign q.cm_ready_o        = ready;
  assign q.bht_wt_index_o    = idx_q;
  assign q.bht_cm_brdir_o    = dir_q;
  assign q.bht_cm_brdir_se_o = se_q;
  assign q.rd_pending_o      = hit;
  assign q.count_o           = cnt;
  assign q.empty_o           = empty;
  assign q.ovf_err_o         = ovf_q;
endmodule

// File: tb/tb_bht_update_queue.sv
// tb_bht_update_queue: directed scenarios plus a scoreboarded random push/hold run
module tb_bht_update_queue;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bht_update_queue_if #(.DEPTH(8), .IDXW(10)) bus ();
  bht_update_queue #(.DEPTH(8), .IDXW(10)) dut (.clock(clock), .reset_n(reset_n), .q(bus.slave));
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    bus.cm0_valid_i = 0; bus.cm0_index_i = '0; bus.cm0_brdir_i = 0;
    bus.cm1_valid_i = 0; bus.cm1_index_i = '0; bus.cm1_brdir_i = 0;
  endtask

  task automatic do_reset();
    idle_in();
    bus.bht_hold_i = 0;
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    bus.rd_index_i = '0;
    do_reset();
    checks++;
    if ({bus.count_o, bus.empty_o, bus.cm_ready_o, bus.bht_cm_brdir_se_o, bus.ovf_err_o, bus.rd_pending_o} !== {4'd0, 5'b11000}) begin
      errors++;
      $display("FAIL reset_flags got cnt=%0d emp=%b rdy=%b se=%b ovf=%b pend=%b want 0 1 1 0 0 0",
               bus.count_o, bus.empty_o, bus.cm_ready_o, bus.bht_cm_brdir_se_o, bus.ovf_err_o, bus.rd_pending_o);
    end
    checks++;
    if ({bus.bht_wt_index_o, bus.bht_cm_brdir_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outs got idx=%h dir=%b want 0 0", bus.bht_wt_index_o, bus.bht_cm_brdir_o);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (bus.bht_cm_brdir_se_o !== 1'b0 || bus.empty_o !== 1'b1) begin
        errors++;
        $display("FAIL idle_se cycle %0d got se=%b emp=%b want 0 1", c, bus.bht_cm_brdir_se_o, bus.empty_o);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.cm0_valid_i = 1; bus.cm0_index_i = 10'h155; bus.cm0_brdir_i = 1;
    tick();
    idle_in();
    checks++;
    if ({bus.count_o, bus.empty_o, bus.bht_cm_brdir_se_o} !== {4'd1, 2'b00}) begin
      errors++;
      $display("FAIL single_n1 got cnt=%0d emp=%b se=%b want 1 0 0", bus.count_o, bus.empty_o, bus.bht_cm_brdir_se_o);
    end
    tick();
    checks++;
    if ({bus.bht_cm_brdir_se_o, bus.bht_wt_index_o, bus.bht_cm_brdir_o, bus.count_o} !== {1'b1, 10'h155, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL single_n2 got se=%b idx=%h dir=%b cnt=%0d want 1 155 1 0",
               bus.bht_cm_brdir_se_o, bus.bht_wt_index_o, bus.bht_cm_brdir_o, bus.count_o);
    end
    tick();
    checks++;
    if ({bus.bht_cm_brdir_se_o, bus.bht_wt_index_o, bus.empty_o} !== {1'b0, 10'h155, 1'b1}) begin
      errors++;
      $display("FAIL single_n3 got se=%b idx=%h emp=%b want 0 155 1", bus.bht_cm_brdir_se_o, bus.bht_wt_index_o, bus.empty_o);
    end
  endtask

  task automatic test_fill_ovf();
    logic [3:0] want;
    do_reset();
    bus.bht_hold_i = 1;
    for (int k = 1; k <= 4; k++) begin
      bus.cm0_valid_i = 1; bus.cm0_index_i = 10'(k); bus.cm0_brdir_i = 0;
      bus.cm1_valid_i = 1; bus.cm1_index_i = 10'(k + 16); bus.cm1_brdir_i = 1;
      tick();
      want = 4'(2 * k);
      checks++;
      if ({bus.count_o, bus.cm_ready_o, bus.ovf_err_o, bus.bht_cm_brdir_se_o} !== {want, k < 4, 2'b00}) begin
        errors++;
        $display("FAIL fill_%0d got cnt=%0d rdy=%b ovf=%b se=%b want %0d %b 0 0",
                 k, bus.count_o, bus.cm_ready_o, bus.ovf_err_o, bus.bht_cm_brdir_se_o, want, k < 4);
      end
    end
    bus.cm1_valid_i = 0;
    tick();
    idle_in();
    checks++;
    if ({bus.count_o, bus.ovf_err_o} !== {4'd8, 1'b1}) begin
      errors++;
      $display("FAIL ovf_set got cnt=%0d ovf=%b want 8 1", bus.count_o, bus.ovf_err_o);
    end
    bus.bht_hold_i = 0;
    tick();
    checks++;
    if ({bus.bht_cm_brdir_se_o, bus.bht_wt_index_o, bus.bht_cm_brdir_o, bus.count_o, bus.ovf_err_o} !== {1'b1, 10'd1, 1'b0, 4'd7, 1'b1}) begin
      errors++;
      $display("FAIL fill_head got se=%b idx=%h dir=%b cnt=%0d ovf=%b want 1 001 0 7 1",
               bus.bht_cm_brdir_se_o, bus.bht_wt_index_o, bus.bht_cm_brdir_o, bus.count_o, bus.ovf_err_o);
    end
  endtask

  task automatic test_order_pending();
    logic [9:0] ei [4] = '{10'h003, 10'h010, 10'h003, 10'h000};
    logic ed [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    bus.rd_index_i = 10'h003;
    bus.cm1_valid_i = 1; bus.cm1_index_i = 10'h003; bus.cm1_brdir_i = 0;
    tick();
    bus.cm0_valid_i = 1; bus.cm0_index_i = 10'h010; bus.cm0_brdir_i = 1;
    bus.cm1_valid_i = 1; bus.cm1_index_i = 10'h003; bus.cm1_brdir_i = 1;
    checks++;
    if ({bus.count_o, bus.bht_cm_brdir_se_o, bus.rd_pending_o} !== {4'd1, 2'b01}) begin
      errors++;
      $display("FAIL order_q1 got cnt=%0d se=%b pend=%b want 1 0 1", bus.count_o, bus.bht_cm_brdir_se_o, bus.rd_pending_o);
    end
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus.bht_cm_brdir_se_o, bus.bht_wt_index_o, bus.bht_cm_brdir_o, bus.rd_pending_o, bus.count_o} !== {1'b1, ei[k], ed[k], 1'b1, 4'(2 - k)}) begin
        errors++;
        $display("FAIL order_%0d got se=%b idx=%h dir=%b pend=%b cnt=%0d want 1 %h %b 1 %0d",
                 k, bus.bht_cm_brdir_se_o, bus.bht_wt_index_o, bus.bht_cm_brdir_o, bus.rd_pending_o, bus.count_o, ei[k], ed[k], 2 - k);
      end
      tick();
    end
    checks++;
    if ({bus.bht_cm_brdir_se_o, bus.rd_pending_o, bus.empty_o} !== 3'b001) begin
      errors++;
      $display("FAIL order_end got se=%b pend=%b emp=%b want 0 0 1", bus.bht_cm_brdir_se_o, bus.rd_pending_o, bus.empty_o);
    end
    bus.rd_index_i = 10'h010;
    #1;
    checks++;
    if (bus.rd_pending_o !== 1'b0) begin
      errors++;
      $display("FAIL pend_other got %b want 0", bus.rd_pending_o);
    end
  endtask

  task automatic test_hold();
    do_reset();
    bus.cm0_valid_i = 1; bus.cm0_index_i = 10'h2aa; bus.cm0_brdir_i = 1;
    tick();
    idle_in();
    bus.bht_hold_i = 1;
    tick();
    bus.bht_hold_i = 0;
    checks++;
    if ({bus.bht_cm_brdir_se_o, bus.count_o} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL hold_block got se=%b cnt=%0d want 0 1", bus.bht_cm_brdir_se_o, bus.count_o);
    end
    tick();
    checks++;
    if ({bus.bht_cm_brdir_se_o, bus.bht_wt_index_o, bus.count_o} !== {1'b1, 10'h2aa, 4'd0}) begin
      errors++;
      $display("FAIL hold_release got se=%b idx=%h cnt=%0d want 1 2aa 0", bus.bht_cm_brdir_se_o, bus.bht_wt_index_o, bus.count_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    bus.bht_hold_i = 1;
    for (int k = 0; k < 3; k++) begin
      bus.cm0_valid_i = 1; bus.cm0_index_i = 10'(k + 100); bus.cm0_brdir_i = 1;
      bus.cm1_valid_i = 1; bus.cm1_index_i = 10'(k + 200); bus.cm1_brdir_i = 1;
      tick();
    end
    idle_in();
    bus.bht_hold_i = 0;
    tick();
    checks++;
    if ({bus.count_o, bus.bht_cm_brdir_se_o} !== {4'd5, 1'b1}) begin
      errors++;
      $display("FAIL mid_drain got cnt=%0d se=%b want 5 1", bus.count_o, bus.bht_cm_brdir_se_o);
    end
    reset_n = 0;
    tick();
    reset_n = 1;
    checks++;
    if ({bus.count_o, bus.bht_cm_brdir_se_o, bus.empty_o, bus.bht_wt_index_o, bus.cm_ready_o} !== {4'd0, 2'b01, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d se=%b emp=%b idx=%h rdy=%b want 0 0 1 000 1",
               bus.count_o, bus.bht_cm_brdir_se_o, bus.empty_o, bus.bht_wt_index_o, bus.cm_ready_o);
    end
  endtask

  task automatic test_random();
    logic [10:0] mq [$];
    logic [10:0] exp_e;
    logic exp_se, mrdy, movf;
    exp_se = 0;
    exp_e = '0;
    movf = 0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      logic v0, v1, h;
      v0 = 1'($urandom_range(1));
      v1 = 1'($urandom_range(1));
      h  = c < 40 ? ($urandom_range(3) == 0) : 1'b0;
      bus.cm0_valid_i = v0 && c < 40; bus.cm0_index_i = 10'($urandom); bus.cm0_brdir_i = 1'($urandom);
      bus.cm1_valid_i = v1 && c < 40; bus.cm1_index_i = 10'($urandom); bus.cm1_brdir_i = 1'($urandom);
      bus.bht_hold_i = h;
      #1;
      mrdy = (8 - mq.size()) >= 2;
      checks++;
      if (bus.cm_ready_o !== mrdy) begin
        errors++;
        $display("FAIL rnd_ready cycle %0d got %b want %b", c, bus.cm_ready_o, mrdy);
      end
      exp_se = mq.size() != 0 && !h;
      if (exp_se) exp_e = mq.pop_front();
      if (mrdy) begin
        if (bus.cm0_valid_i) mq.push_back({bus.cm0_index_i, bus.cm0_brdir_i});
        if (bus.cm1_valid_i) mq.push_back({bus.cm1_index_i, bus.cm1_brdir_i});
      end else if (bus.cm0_valid_i || bus.cm1_valid_i) movf = 1;
      tick();
      checks++;
      if (bus.bht_cm_brdir_se_o !== exp_se || (exp_se && {bus.bht_wt_index_o, bus.bht_cm_brdir_o} !== exp_e) || bus.count_o !== 4'(mq.size())) begin
        errors++;
        $display("FAIL rnd_drain cycle %0d got se=%b e=%h cnt=%0d want se=%b e=%h cnt=%0d",
                 c, bus.bht_cm_brdir_se_o, {bus.bht_wt_index_o, bus.bht_cm_brdir_o}, bus.count_o, exp_se, exp_e, mq.size());
      end
    end
    idle_in();
    checks++;
    if ({bus.empty_o, bus.ovf_err_o} !== {mq.size() == 0, movf}) begin
      errors++;
      $display("FAIL rnd_final got emp=%b ovf=%b want %b %b", bus.empty_o, bus.ovf_err_o, mq.size() == 0, movf);
    end
  endtask

  initial begin
    idle_in();
    bus.bht_hold_i = 0;
    bus.rd_index_i = '0;
    test_reset();
    test_single();
    test_fill_ovf();
    test_order_pending();
    test_hold();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
